// File: rtl/mem_arb_pkg.sv
// Shared types for the I/D-cache memory port arbiter: FSM states, width defaults, requester IDs.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2,
    DONE    = 2'd3
  } arb_state_t;

  localparam int DEF_ADDR_W = 28;
  localparam int DEF_DATA_W = 128;

  typedef logic req_id_t;
  localparam req_id_t REQ_I = 1'b0;
  localparam req_id_t REQ_D = 1'b1;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant selector; MEM_ARB_RR_EN selects round-robin, otherwise D-cache has fixed priority.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic    i_req,
  input  logic    d_req,
  input  req_id_t last_grant,
  output req_id_t grant
);

`ifdef MEM_ARB_RR_EN
  always_comb begin
    grant = REQ_I;
    if (i_req && d_req) begin
      grant = (last_grant == REQ_D) ? REQ_I : REQ_D;
    end else if (d_req) begin
      grant = REQ_D;
    end
  end
`else
  // Fixed priority needs neither the pointer nor the I request to decide.
  logic unused_pick;
  assign unused_pick = last_grant ^ i_req;
  assign grant = d_req ? REQ_D : REQ_I;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between I- and D-cache; request registered to mem_* one cycle after IDLE, ready/rdata routed combinationally.
// Requests are held by the caches until ready; DONE adds one dead cycle per transfer. MEM_ARB_RR_EN enables round-robin.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_read,
  input  logic              i_write,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic              i_ready,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]  conflict_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  arb_state_t        state_q, state_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              i_req, d_req, waiting;
  req_id_t           grant, last_q;

  assign i_req = i_read | i_write;
  assign d_req = d_read | d_write;

`ifdef MEM_ARB_RR_EN
  req_id_t last_d;
`else
  assign last_q = REQ_D;
`endif

  mem_arb_pick u_pick (
    .i_req      (i_req),
    .d_req      (d_req),
    .last_grant (last_q),
    .grant      (grant)
  );

  assign waiting = ((state_q == GRANT_I) && d_req) || ((state_q == GRANT_D) && i_req);

  always_comb begin
    state_d     = state_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cnt_d       = cnt_q;
`ifdef MEM_ARB_RR_EN
    last_d      = last_q;
`endif
    if (waiting && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_ONE;
    end
    case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          // Write wins when a requester illegally raises both.
          if (grant == REQ_D) begin
            state_d     = GRANT_D;
            mem_write_d = d_write;
            mem_read_d  = d_read & ~d_write;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
          end else begin
            state_d     = GRANT_I;
            mem_write_d = i_write;
            mem_read_d  = i_read & ~i_write;
            mem_addr_d  = i_addr;
            mem_wdata_d = i_wdata;
          end
`ifdef MEM_ARB_RR_EN
          last_d = grant;
`endif
        end
      end
      GRANT_I, GRANT_D: begin
        if (mem_ready) begin
          state_d     = DONE;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cnt_q       <= '0;
`ifdef MEM_ARB_RR_EN
      last_q      <= REQ_D;
`endif
    end else begin
      state_q     <= state_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cnt_q       <= cnt_d;
`ifdef MEM_ARB_RR_EN
      last_q      <= last_d;
`endif
    end
  end

  assign mem_read     = mem_read_q;
  assign mem_write    = mem_write_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign conflict_cnt = cnt_q;
  assign i_ready      = (state_q == GRANT_I) && mem_ready;
  assign d_ready      = (state_q == GRANT_D) && mem_ready;
  assign i_rdata      = mem_rdata;
  assign d_rdata      = mem_rdata;

endmodule
